// File: rtl/freq_count_latch.sv
`default_nettype none
// ============================================================================
// Module   : freq_count_latch
// Purpose  : Measurement half of the frequency meter. Counts rising edges of
//            FSIN in BCD while CNT_EN is high, clears on RST_CNT and latches
//            the running count into DOUT/OVF on a rising edge of LOAD.
// Ports    : CLK      - system clock, all state updates on rising edge
//            RST      - synchronous active-high reset
//            FSIN     - signal under test (asynchronous)
//            CNT_EN   - count gate, level (asynchronous)
//            RST_CNT  - count/overflow clear, level (asynchronous)
//            LOAD     - rising edge latches count into DOUT (asynchronous)
//            DOUT     - latched BCD result, digit 0 in bits [3:0]
//            OVF      - latched sticky overflow flag
//            VALID    - one-cycle pulse when DOUT/OVF update
// Revision : 1.0 - initial release
// ============================================================================
module freq_count_latch #(
  parameter int DIGITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FSIN,
  input  logic                  CNT_EN,
  input  logic                  RST_CNT,
  input  logic                  LOAD,
  output logic [4*DIGITS-1:0]   DOUT,
  output logic                  OVF,
  output logic                  VALID
);

  localparam int c_cnt_w = 4 * DIGITS;

  // --------------------------------------------------------------------------
  // Input synchronizers. FSIN and LOAD carry an extra delay flop so a rising
  // edge can be detected one cycle after the second sync stage.
  // --------------------------------------------------------------------------
  logic r_fsin_s1, r_fsin_s2, r_fsin_d;
  logic r_en_s1,   r_en_s2;
  logic r_rc_s1,   r_rc_s2;
  logic r_load_s1, r_load_s2, r_load_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fsin_s1 <= 1'b0;
      r_fsin_s2 <= 1'b0;
      r_fsin_d  <= 1'b0;
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_rc_s1   <= 1'b0;
      r_rc_s2   <= 1'b0;
      // LOAD chain resets high so a LOAD held high through reset does not
      // look like a fresh rising edge afterwards.
      r_load_s1 <= 1'b1;
      r_load_s2 <= 1'b1;
      r_load_d  <= 1'b1;
    end else begin
      r_fsin_s1 <= FSIN;
      r_fsin_s2 <= r_fsin_s1;
      r_fsin_d  <= r_fsin_s2;
      r_en_s1   <= CNT_EN;
      r_en_s2   <= r_en_s1;
      r_rc_s1   <= RST_CNT;
      r_rc_s2   <= r_rc_s1;
      r_load_s1 <= LOAD;
      r_load_s2 <= r_load_s1;
      r_load_d  <= r_load_s2;
    end
  end

  logic w_fsin_edge;
  logic w_load_edge;

  // CNT_EN/RST_CNT are used straight from sync stage 2, which lines them up
  // with the FSIN edge pulse (also derived from stage 2), preserving gate
  // timing relative to the measured signal.
  assign w_fsin_edge = r_fsin_s2 & ~r_fsin_d;
  assign w_load_edge = r_load_s2 & ~r_load_d;

  // --------------------------------------------------------------------------
  // BCD increment: ripple carry across digits. w_carry[i] means digit i
  // receives +1; a digit at 9 wraps to 0 and passes the carry upward.
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ovf;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic [DIGITS:0]    w_carry;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_nib;
      logic       w_is9;

      assign w_nib = r_cnt[4*gi +: 4];
      assign w_is9 = (w_nib == 4'd9);

      assign w_cnt_inc[4*gi +: 4] = !w_carry[gi] ? w_nib :
                                    (w_is9 ? 4'd0 : w_nib + 4'd1);
      assign w_carry[gi+1]        = w_carry[gi] & w_is9;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Running count. Clear has priority over counting; carry out of the top
  // digit leaves the count at zero (w_cnt_inc is all zeros then) and sets
  // the sticky overflow flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_rc_s2) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_en_s2 && w_fsin_edge) begin
      r_cnt <= w_cnt_inc;
      if (w_carry[DIGITS]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output latch. Samples the registered count, so a same-cycle clear or
  // increment is not visible in the latched value.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT  <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else begin
      VALID <= w_load_edge;
      if (w_load_edge) begin
        DOUT <= r_cnt;
        OVF  <= r_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_count_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_count_latch
// Purpose  : Directed self-checking bench for freq_count_latch. Drives an
//            8-digit and a 2-digit instance from the same stimulus; the
//            2-digit instance exercises overflow wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_count_latch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FSIN;
  logic        CNT_EN;
  logic        RST_CNT;
  logic        LOAD;
  logic [31:0] DOUT;
  logic        OVF;
  logic        VALID;
  logic [7:0]  DOUT_S;
  logic        OVF_S;
  logic        VALID_S;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  freq_count_latch #(.DIGITS(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .FSIN   (FSIN),
    .CNT_EN (CNT_EN),
    .RST_CNT(RST_CNT),
    .LOAD   (LOAD),
    .DOUT   (DOUT),
    .OVF    (OVF),
    .VALID  (VALID)
  );

  freq_count_latch #(.DIGITS(2)) dut_s (
    .CLK    (CLK),
    .RST    (RST),
    .FSIN   (FSIN),
    .CNT_EN (CNT_EN),
    .RST_CNT(RST_CNT),
    .LOAD   (LOAD),
    .DOUT   (DOUT_S),
    .OVF    (OVF_S),
    .VALID  (VALID_S)
  );

  // Every running-count nibble must stay within 0..9 on every cycle.
  always @(negedge CLK) begin
    logic [31:0] c8;
    logic [7:0]  c2;
    c8 = dut.r_cnt;
    c2 = dut_s.r_cnt;
    for (int i = 0; i < 8; i++) begin
      if (c8[4*i +: 4] > 4'd9) begin
        fails++;
        $error("FAIL nibble8: observed %h expected each digit <= 9", c8);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (c2[4*i +: 4] > 4'd9) begin
        fails++;
        $error("FAIL nibble2: observed %h expected each digit <= 9", c2);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      FSIN = 1'b1;
      repeat (4) tick();
      FSIN = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic rst_cnt_pulse();
    RST_CNT = 1'b1;
    repeat (3) tick();
    RST_CNT = 1'b0;
    repeat (3) tick();
  endtask

  // LOAD rises before edge k; VALID/DOUT update at k+2, VALID drops at k+3.
  task automatic do_load(input string tag, input logic [31:0] exp8, input logic expovf8,
                         input logic [7:0] exp2, input logic expovf2);
    LOAD = 1'b1;
    tick();                               // edge k
    chk({tag, "_valid_k"},   {31'd0, VALID}, 32'd0);
    tick();                               // edge k+1
    chk({tag, "_valid_k1"},  {31'd0, VALID}, 32'd0);
    tick();                               // edge k+2
    chk({tag, "_valid"},     {31'd0, VALID},   32'd1);
    chk({tag, "_dout"},      DOUT,             exp8);
    chk({tag, "_ovf"},       {31'd0, OVF},     {31'd0, expovf8});
    chk({tag, "_dout_s"},    {24'd0, DOUT_S},  {24'd0, exp2});
    chk({tag, "_ovf_s"},     {31'd0, OVF_S},   {31'd0, expovf2});
    chk({tag, "_valid_s"},   {31'd0, VALID_S}, 32'd1);
    tick();                               // edge k+3
    chk({tag, "_valid_k3"},  {31'd0, VALID}, 32'd0);
    LOAD = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    RST = 1'b1; FSIN = 1'b0; CNT_EN = 1'b0; RST_CNT = 1'b0; LOAD = 1'b0;

    // Reset
    repeat (2) tick();
    chk("rst_dout",  DOUT,            32'd0);
    chk("rst_ovf",   {31'd0, OVF},    32'd0);
    chk("rst_valid", {31'd0, VALID},  32'd0);
    chk("rst_dout_s", {24'd0, DOUT_S}, 32'd0);
    RST = 1'b0;
    repeat (4) tick();
    chk("post_rst_valid", {31'd0, VALID}, 32'd0);

    // Basic count
    CNT_EN = 1'b1;
    pulses(5);
    CNT_EN = 1'b0;
    do_load("basic", 32'h0000_0005, 1'b0, 8'h05, 1'b0);

    // BCD carry (cumulative totals 9, 10, 99, 1000)
    rst_cnt_pulse();
    CNT_EN = 1'b1;
    pulses(9);
    do_load("bcd9",    32'h0000_0009, 1'b0, 8'h09, 1'b0);
    pulses(1);
    do_load("bcd10",   32'h0000_0010, 1'b0, 8'h10, 1'b0);
    pulses(89);
    do_load("bcd99",   32'h0000_0099, 1'b0, 8'h99, 1'b0);
    pulses(901);
    do_load("bcd1000", 32'h0000_1000, 1'b0, 8'h00, 1'b1);

    // Overflow on the 2-digit instance
    rst_cnt_pulse();
    pulses(101);
    do_load("ovf101", 32'h0000_0101, 1'b0, 8'h01, 1'b1);
    rst_cnt_pulse();
    pulses(3);
    do_load("ovfclr", 32'h0000_0003, 1'b0, 8'h03, 1'b0);

    // Gating: no count while CNT_EN low
    rst_cnt_pulse();
    CNT_EN = 1'b0;
    repeat (3) tick();
    pulses(7);
    do_load("gate_off", 32'd0, 1'b0, 8'h00, 1'b0);

    // RST_CNT held high overrides CNT_EN
    RST_CNT = 1'b1;
    CNT_EN  = 1'b1;
    pulses(4);
    do_load("rstcnt_hold", 32'd0, 1'b0, 8'h00, 1'b0);
    RST_CNT = 1'b0;
    repeat (3) tick();

    // Simultaneous LOAD and RST_CNT: old count latched, then cleared
    pulses(12);
    RST_CNT = 1'b1;
    do_load("simul", 32'h0000_0012, 1'b0, 8'h12, 1'b0);
    RST_CNT = 1'b0;
    repeat (3) tick();
    do_load("simul_after", 32'd0, 1'b0, 8'h00, 1'b0);

    // Reset mid-operation with LOAD held high
    pulses(6);
    do_load("pre_rst", 32'h0000_0006, 1'b0, 8'h06, 1'b0);
    LOAD = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_dout",  DOUT,           32'd0);
    chk("midrst_ovf",   {31'd0, OVF},   32'd0);
    chk("midrst_valid", {31'd0, VALID}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_novalid", {31'd0, VALID}, 32'd0);
    end
    chk("midrst_dout_hold", DOUT, 32'd0);
    LOAD = 1'b0;
    repeat (3) tick();
    pulses(2);
    do_load("post_midrst", 32'h0000_0002, 1'b0, 8'h02, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
